centroid_unload_tx: RTL

//  Sends the final centroid set from the classification block back to the core after k-means converges.
//  A controller start pulse snapshots all centroid registers. The block then serialises the first K

---
 rtl/centroid_unload_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/centroid_unload_tx.sv
// Centroid unload: snapshots all centroid registers on start and serialises the
// first K words to the core over a valid/ready handshake, index 0 first.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, num_centroids     unload request and requested word count K
//   centroid_in_1..8         live centroid register values
//   centroid_output_to_core  word presented to the core (with out_index/out_last)
//   out_valid, out_ready     outbound handshake
//   busy, done               unload in progress / one-cycle completion pulse
module centroid_unload_tx #(
    parameter int dataWidth    = 91,
    parameter int centroid_num = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           num_centroids,
    input  logic [dataWidth-1:0] centroid_in_1,
    input  logic [dataWidth-1:0] centroid_in_2,
    input  logic [dataWidth-1:0] centroid_in_3,
    input  logic [dataWidth-1:0] centroid_in_4,
    input  logic [dataWidth-1:0] centroid_in_5,
    input  logic [dataWidth-1:0] centroid_in_6,
    input  logic [dataWidth-1:0] centroid_in_7,
    input  logic [dataWidth-1:0] centroid_in_8,
    output logic [dataWidth-1:0] centroid_output_to_core,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [3:0] KMax = 4'(centroid_num);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [3:0]           keff_q, keff_d;
    logic [dataWidth-1:0] shadow_q [8];
    logic [dataWidth-1:0] shadow_d [8];
    logic [dataWidth-1:0] live     [8];
    logic [3:0]           keff_new;
    logic                 is_last;

    always_comb begin
        live[0] = centroid_in_1;
        live[1] = centroid_in_2;
        live[2] = centroid_in_3;
        live[3] = centroid_in_4;
        live[4] = centroid_in_5;
        live[5] = centroid_in_6;
        live[6] = centroid_in_7;
        live[7] = centroid_in_8;
    end

    // Requests above the slot count are clamped; zero stays zero.
    assign keff_new = (num_centroids > KMax) ? KMax : num_centroids;
    assign is_last  = ({1'b0, idx_q} == (keff_q - 4'd1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        keff_d   = keff_q;
        shadow_d = shadow_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = live;
                    keff_d   = keff_new;
                    idx_d    = 3'd0;
                    state_d  = (keff_new == 4'd0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            keff_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            keff_q   <= keff_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        out_valid               = (state_q == SEND);
        busy                    = (state_q == SEND);
        done                    = (state_q == FIN);
        centroid_output_to_core = out_valid ? shadow_q[idx_q] : '0;
        out_index               = out_valid ? idx_q : 3'd0;
        out_last                = out_valid && is_last;
    end

endmodule
